// File: rtl/lf_gain_sched.sv
// lf_gain_sched: loop-filter gain scheduler and carrier lock detector.
// Windowed mean |pd_err| steps SEARCH/PULL/TRACK gains with hysteresis.
//
// Ports:
//   sys_clk   in   system clock
//   rst       in   synchronous active-high reset
//   clk_en    in   symbol strobe; pd_err sampled when high
//   pd_err    in   signed phase-detector error, ERR_W bits
//   hold      in   (LF_SCHED_HOLD_EN only) ignore strobes while high
//   gain_sel  out  0 = SEARCH, 1 = PULL, 2 = TRACK
//   lock      out  high while in TRACK
//   acc_clr   out  one-cycle loop-filter integrator clear
//   win_done  out  one-cycle pulse when a window closes
//   err_sum   out  |err| sum of the last completed window
//
// Build option: define LF_SCHED_HOLD_EN to add the hold input.
module lf_gain_sched #(
  parameter int ERR_W     = 16,
  parameter int WIN       = 16,
  parameter int LOCK_TH   = 3200,
  parameter int UNLOCK_TH = 12800,
  parameter int GOOD_N    = 2,
  parameter int BAD_N     = 3
) (
  input  logic                            sys_clk,
  input  logic                            rst,
  input  logic                            clk_en,
  input  logic signed [ERR_W-1:0]         pd_err,
`ifdef LF_SCHED_HOLD_EN
  input  logic                            hold,
`endif
  output logic [1:0]                      gain_sel,
  output logic                            lock,
  output logic                            acc_clr,
  output logic                            win_done,
  output logic [ERR_W+$clog2(WIN)-1:0]    err_sum
);

  localparam int LW = $clog2(WIN);
  localparam int AW = ERR_W - 1 + LW;
  localparam int SW = ERR_W + LW;

  typedef enum logic [1:0] {
    S_SEARCH = 2'd0,
    S_PULL   = 2'd1,
    S_TRACK  = 2'd2
  } st_t;

  st_t           state_q;
  st_t           state_d;
  logic [AW-1:0] sum_q;
  logic [LW-1:0] win_cnt_q;
  logic [3:0]    good_cnt_q;
  logic [3:0]    bad_cnt_q;
  logic [3:0]    good_d;
  logic [3:0]    bad_d;
  logic [1:0]    gain_sel_q;
  logic          lock_q;
  logic          acc_clr_q;
  logic          win_done_q;
  logic [SW-1:0] err_sum_q;

  logic             hold_w;
  logic             strobe;
  logic [ERR_W-1:0] neg_err;
  logic [ERR_W-2:0] abs_err;
  logic [AW-1:0]    total;
  logic             closing;
  logic             good_w;
  logic             bad_w;
  logic [3:0]       good_inc;
  logic [3:0]       bad_inc;
  logic             clr_d;

`ifdef LF_SCHED_HOLD_EN
  assign hold_w = hold;
`else
  assign hold_w = 1'b0;
`endif

  assign strobe  = clk_en & ~hold_w;
  assign neg_err = -pd_err;

  // Most-negative input has no positive twin; clamp to max.
  always_comb begin
    abs_err = '0;
    if (!pd_err[ERR_W-1])
      abs_err = pd_err[ERR_W-2:0];
    else if (pd_err == {1'b1, {(ERR_W-1){1'b0}}})
      abs_err = '1;
    else
      abs_err = neg_err[ERR_W-2:0];
  end

  assign total   = sum_q + AW'(abs_err);
  assign closing = strobe && (win_cnt_q == LW'(WIN - 1));
  assign good_w  = 32'(total) < 32'(LOCK_TH);
  assign bad_w   = 32'(total) > 32'(UNLOCK_TH);

  // Saturate so long runs in one state cannot wrap to a match.
  assign good_inc = (good_cnt_q == 4'hF) ?
                    good_cnt_q : good_cnt_q + 4'd1;
  assign bad_inc  = (bad_cnt_q == 4'hF) ?
                    bad_cnt_q : bad_cnt_q + 4'd1;

  always_comb begin
    state_d = state_q;
    clr_d   = 1'b0;
    good_d  = good_cnt_q;
    bad_d   = bad_cnt_q;
    unique case (1'b1)
      good_w: begin
        good_d = good_inc;
        bad_d  = '0;
      end
      bad_w: begin
        bad_d  = bad_inc;
        good_d = '0;
      end
      default: ;
    endcase
    case (state_q)
      S_SEARCH: begin
        if (good_w && good_inc == 4'(GOOD_N))
          state_d = S_PULL;
      end
      S_PULL: begin
        if (bad_w) begin
          state_d = S_SEARCH;
          clr_d   = 1'b1;
        end else if (good_w && good_inc == 4'(GOOD_N)) begin
          state_d = S_TRACK;
        end
      end
      S_TRACK: begin
        if (bad_w && bad_inc == 4'(BAD_N)) begin
          state_d = S_SEARCH;
          clr_d   = 1'b1;
        end
      end
      default: state_d = S_SEARCH;
    endcase
    if (state_d != state_q) begin
      good_d = '0;
      bad_d  = '0;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state_q    <= S_SEARCH;
      sum_q      <= '0;
      win_cnt_q  <= '0;
      good_cnt_q <= '0;
      bad_cnt_q  <= '0;
      gain_sel_q <= 2'd0;
      lock_q     <= 1'b0;
      acc_clr_q  <= 1'b0;
      win_done_q <= 1'b0;
      err_sum_q  <= '0;
    end else begin
      win_done_q <= 1'b0;
      acc_clr_q  <= 1'b0;
      if (closing) begin
        sum_q      <= '0;
        win_cnt_q  <= '0;
        err_sum_q  <= SW'(total);
        win_done_q <= 1'b1;
        acc_clr_q  <= clr_d;
        state_q    <= state_d;
        gain_sel_q <= state_d;
        lock_q     <= (state_d == S_TRACK);
        good_cnt_q <= good_d;
        bad_cnt_q  <= bad_d;
      end else if (strobe) begin
        sum_q     <= total;
        win_cnt_q <= win_cnt_q + LW'(1);
      end
    end
  end

  assign gain_sel = gain_sel_q;
  assign lock     = lock_q;
  assign acc_clr  = acc_clr_q;
  assign win_done = win_done_q;
  assign err_sum  = err_sum_q;

endmodule
